load_store_unit: RTL and testbench

- Data-memory stage directly downstream of the ALU: takes the ALU result as the effective address and rs2 as store data, performs one bus transaction per load/store, and returns a sign- or zero-extended load value to the writeback mux.
- Stalls the single-cycle core while a bus access is outstanding.
- Reports misaligned, illegal-funct3 and bus-timeout faults.

---
 rtl/lsu_pkg.sv | 55 +++++
 rtl/load_store_unit_if.sv | 20 ++
 rtl/load_align.sv | 26 ++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types, codes and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_MISALIGNED = 2'b01,
    CAUSE_ILLEGAL    = 2'b10,
    CAUSE_TIMEOUT    = 2'b11
  } cause_t;

  // Width never drops below 1 so a disabled timeout still has a legal counter.
  function automatic int tmo_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic illegal_f3(input logic [2:0] f3, input logic is_store);
    if (is_store) return f3[2] | (f3[1:0] == 2'b11);
    return (f3 == 3'b011) | (f3[2:1] == 2'b11);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return ((f3[1:0] == 2'b01) & lane[0]) | ((f3[1:0] == 2'b10) & (lane != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busByteEn;
  logic [31:0] busRdata;
  logic        busAck;

  modport master (
    output busReq, busWe, busAddr, busWdata, busByteEn,
    input  busRdata, busAck
  );

  modport slave (
    input  busReq, busWe, busAddr, busWdata, busByteEn,
    output busRdata, busAck
  );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a read word and sign/zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = rdata[{lane, 3'b000} +: 8];
    sel_h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    value = {{24{sel_b[7]}}, sel_b};
      F3_BU:   value = {24'h0, sel_b};
      F3_H:    value = {{16{sel_h[15]}}, sel_h};
      F3_HU:   value = {16'h0, sel_h};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: one bus transaction per load/store, stalls the core while
// outstanding, and reports misaligned / illegal-funct3 / timeout faults.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic [2:0]         funct3,
  input  logic [31:0]        address,
  input  logic [31:0]        storeData,
  output logic [31:0]        loadData,
  output logic               stall,
  output logic               done,
  output logic               fault,
  output logic [1:0]         faultCause,
  load_store_unit_if.master  bus
);

  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

  lsu_state_t state, state_nxt;
  cause_t     cause_nxt, cause_q;
  logic       fault_nxt, fault_q;
  logic       req, f3_bad, addr_bad;
  logic       cap_req, ld_cap, cnt_inc, tmo_hit;
  logic [CNT_W-1:0] tmo_cnt;
  logic       we_q;
  logic [2:0] f3_q;
  logic [1:0] lane_q;
  logic [31:0] addr_q, wdata_q, align_val;
  logic [3:0] be_q;

  assign req      = memRead | memWrite;
  assign f3_bad   = illegal_f3(funct3, memWrite);
  assign addr_bad = misaligned(funct3, address[1:0]);
  // Fires on the BUSY cycle whose miss would make the count reach the limit.
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) &&
                    (({1'b0, tmo_cnt} + 1'b1) == (CNT_W+1)'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_req   = 1'b0;
    ld_cap    = 1'b0;
    cnt_inc   = 1'b0;
    fault_nxt = 1'b0;
    cause_nxt = CAUSE_NONE;
    unique case (state)
      S_IDLE: if (req) begin
        if (f3_bad) begin
          state_nxt = S_DONE;
          fault_nxt = 1'b1;
          cause_nxt = CAUSE_ILLEGAL;
        end else if (addr_bad) begin
          state_nxt = S_DONE;
          fault_nxt = 1'b1;
          cause_nxt = CAUSE_MISALIGNED;
        end else begin
          cap_req   = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.busAck) begin
          ld_cap    = ~we_q;
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
          fault_nxt = 1'b1;
          cause_nxt = CAUSE_TIMEOUT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadData <= '0;
      tmo_cnt  <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      lane_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      fault_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      if (cap_req) begin
        we_q    <= memWrite;
        f3_q    <= funct3;
        lane_q  <= address[1:0];
        addr_q  <= {address[31:2], 2'b00};
        be_q    <= byte_en(funct3, address[1:0]);
        wdata_q <= memWrite ? store_wdata(funct3, storeData) : 32'h0;
        tmo_cnt <= '0;
      end else if (cnt_inc) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (ld_cap) loadData <= align_val;
      if (state_nxt == S_DONE && state != S_DONE) begin
        fault_q <= fault_nxt;
        cause_q <= cause_nxt;
      end
    end
  end

  load_align u_load_align (
    .rdata  (bus.busRdata),
    .lane   (lane_q),
    .funct3 (f3_q),
    .value  (align_val)
  );

  // Bus outputs are gated by BUSY so an async reset drops them at once.
  assign bus.busReq    = (state == S_BUSY);
  assign bus.busWe     = (state == S_BUSY) & we_q;
  assign bus.busAddr   = (state == S_BUSY) ? addr_q  : 32'h0;
  assign bus.busWdata  = (state == S_BUSY) ? wdata_q : 32'h0;
  assign bus.busByteEn = (state == S_BUSY) ? be_q    : 4'h0;

  assign stall      = rst_n & (((state == S_IDLE) & req) | (state == S_BUSY));
  assign done       = (state == S_DONE);
  assign fault      = done & fault_q;
  assign faultCause = done ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=4) and standalone load_align.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] address, storeData, loadData;
  logic        stall, done, fault;
  logic [1:0]  faultCause;

  logic [31:0] al_rdata, al_value;
  logic [1:0]  al_lane;
  logic [2:0]  al_f3;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit_if bif ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .address    (address),
    .storeData  (storeData),
    .loadData   (loadData),
    .stall      (stall),
    .done       (done),
    .fault      (fault),
    .faultCause (faultCause),
    .bus        (bif.master)
  );

  load_align u_align (
    .rdata  (al_rdata),
    .lane   (al_lane),
    .funct3 (al_f3),
    .value  (al_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  lane;
    logic [2:0]  f3;
    logic [31:0] exp;
  } al_vec_t;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, sd;
    int          ack_at;
    logic [31:0] rdata, ld, baddr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we, flt;
    logic [1:0]  cause;
    int          lat, busy, stl;
  } acc_t;

  // Drives one request and a memory responding on BUSY cycle ack_at (0 = never).
  task automatic run_access(input acc_t v,
                            output logic [31:0] o_addr, output logic [31:0] o_wd,
                            output logic [3:0] o_be, output logic o_we,
                            output logic o_flt, output logic [1:0] o_cause,
                            output int o_lat, output int o_busy, output int o_stl,
                            output logic o_stable, output logic o_ok);
    o_addr = '0; o_wd = '0; o_be = '0; o_we = 1'b0; o_flt = 1'b0; o_cause = '0;
    o_lat = 0; o_busy = 0; o_stl = 0; o_stable = 1'b1; o_ok = 1'b0;
    @(negedge clk);
    memRead = v.rd; memWrite = v.wr; funct3 = v.f3; address = v.addr; storeData = v.sd;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (stall) o_stl++;
      if (done) begin
        o_flt = fault; o_cause = faultCause; o_lat = c + 1; o_ok = 1'b1;
        break;
      end
      if (bif.busReq) begin
        o_busy++;
        if (o_busy == 1) begin
          o_addr = bif.busAddr; o_wd = bif.busWdata; o_be = bif.busByteEn; o_we = bif.busWe;
        end else if (o_addr !== bif.busAddr || o_wd !== bif.busWdata ||
                     o_be !== bif.busByteEn || o_we !== bif.busWe) begin
          o_stable = 1'b0;
        end
      end
      bif.busAck   = bif.busReq && (o_busy == v.ack_at);
      bif.busRdata = bif.busAck ? v.rdata : 32'h0BAD0BAD;
      @(negedge clk);
      #1;
    end
    bif.busAck = 1'b0;
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  al_vec_t al_tbl [8];
  acc_t    tbl [12];

  initial begin
    logic [31:0] r_addr, r_wd;
    logic [3:0]  r_be;
    logic        r_we, r_flt, r_stable, r_ok;
    logic [1:0]  r_cause;
    int          r_lat, r_busy, r_stl;
    logic [31:0] ld_before;

    al_tbl[0] = '{32'h80FF1234, 2'd3, 3'b000, 32'hFFFFFF80};
    al_tbl[1] = '{32'h80FF1234, 2'd2, 3'b000, 32'hFFFFFFFF};
    al_tbl[2] = '{32'h80FF1234, 2'd1, 3'b100, 32'h00000012};
    al_tbl[3] = '{32'h80FF1234, 2'd0, 3'b000, 32'h00000034};
    al_tbl[4] = '{32'h80010000, 2'd2, 3'b001, 32'hFFFF8001};
    al_tbl[5] = '{32'h80010000, 2'd2, 3'b101, 32'h00008001};
    al_tbl[6] = '{32'h00017FFF, 2'd0, 3'b001, 32'h00007FFF};
    al_tbl[7] = '{32'hDEADBEEF, 2'd0, 3'b010, 32'hDEADBEEF};

    //          rd wr f3      addr          sd            ack rdata         ld            baddr         be       wd            we flt cause lat busy stl
    tbl[0]  = '{1, 0, 3'b000, 32'h00001003, 32'hFFFFFFFF, 2, 32'h80FF1234, 32'hFFFFFF80, 32'h00001000, 4'b1000, 32'h00000000, 0, 0, 2'b00, 4, 2, 3};
    tbl[1]  = '{1, 0, 3'b101, 32'h00001002, 32'hFFFFFFFF, 1, 32'h80010000, 32'h00008001, 32'h00001000, 4'b1100, 32'h00000000, 0, 0, 2'b00, 3, 1, 2};
    tbl[2]  = '{1, 0, 3'b001, 32'h00001002, 32'hFFFFFFFF, 1, 32'h80010000, 32'hFFFF8001, 32'h00001000, 4'b1100, 32'h00000000, 0, 0, 2'b00, 3, 1, 2};
    tbl[3]  = '{0, 1, 3'b001, 32'h00002002, 32'h1234ABCD, 3, 32'h00000000, 32'hFFFF8001, 32'h00002000, 4'b1100, 32'hABCDABCD, 1, 0, 2'b00, 5, 3, 4};
    tbl[4]  = '{1, 0, 3'b010, 32'h00001001, 32'hFFFFFFFF, 1, 32'h00000000, 32'hFFFF8001, 32'h00000000, 4'b0000, 32'h00000000, 0, 1, 2'b01, 2, 0, 1};
    tbl[5]  = '{1, 0, 3'b011, 32'h00001000, 32'hFFFFFFFF, 1, 32'h00000000, 32'hFFFF8001, 32'h00000000, 4'b0000, 32'h00000000, 0, 1, 2'b10, 2, 0, 1};
    tbl[6]  = '{0, 1, 3'b101, 32'h00001001, 32'h12345678, 1, 32'h00000000, 32'hFFFF8001, 32'h00000000, 4'b0000, 32'h00000000, 0, 1, 2'b10, 2, 0, 1};
    tbl[7]  = '{1, 0, 3'b010, 32'h00001008, 32'hFFFFFFFF, 0, 32'h00000000, 32'hFFFF8001, 32'h00001008, 4'b1111, 32'h00000000, 0, 1, 2'b11, 6, 4, 5};
    tbl[8]  = '{1, 1, 3'b000, 32'h00003001, 32'h000000A5, 1, 32'h00000000, 32'hFFFF8001, 32'h00003000, 4'b0010, 32'hA5A5A5A5, 1, 0, 2'b00, 3, 1, 2};
    tbl[9]  = '{1, 0, 3'b100, 32'h00001001, 32'hFFFFFFFF, 1, 32'h0000F700, 32'h000000F7, 32'h00001000, 4'b0010, 32'h00000000, 0, 0, 2'b00, 3, 1, 2};
    tbl[10] = '{1, 0, 3'b010, 32'h0000100C, 32'hFFFFFFFF, 2, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000100C, 4'b1111, 32'h00000000, 0, 0, 2'b00, 4, 2, 3};
    tbl[11] = '{1, 0, 3'b000, 32'h00004000, 32'hFFFFFFFF, 1, 32'hFFFFFF7F, 32'h0000007F, 32'h00004000, 4'b0001, 32'h00000000, 0, 0, 2'b00, 3, 1, 2};

    rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = '0;
    address = '0; storeData = '0; bif.busAck = 1'b0; bif.busRdata = '0;
    al_rdata = '0; al_lane = '0; al_f3 = '0;

    for (int i = 0; i < 8; i++) begin
      al_rdata = al_tbl[i].rdata; al_lane = al_tbl[i].lane; al_f3 = al_tbl[i].f3;
      #1;
      chk($sformatf("align[%0d]", i), al_value, al_tbl[i].exp);
    end

    repeat (2) @(negedge clk);
    chk("rst loadData", loadData, 32'h0);
    chk("rst stall/done/fault/cause", {stall, done, fault, faultCause}, 32'h0);
    chk("rst bus ctrl", {bif.busReq, bif.busWe, bif.busByteEn}, 32'h0);
    chk("rst busAddr", bif.busAddr, 32'h0);
    chk("rst busWdata", bif.busWdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_access(tbl[i], r_addr, r_wd, r_be, r_we, r_flt, r_cause, r_lat, r_busy, r_stl, r_stable, r_ok);
      chk($sformatf("row%0d completed", i), r_ok, 1);
      chk($sformatf("row%0d loadData", i), loadData, tbl[i].ld);
      chk($sformatf("row%0d busAddr", i), r_addr, tbl[i].baddr);
      chk($sformatf("row%0d busByteEn", i), r_be, tbl[i].be);
      chk($sformatf("row%0d busWdata", i), r_wd, tbl[i].wd);
      chk($sformatf("row%0d busWe", i), r_we, tbl[i].we);
      chk($sformatf("row%0d fault", i), r_flt, tbl[i].flt);
      chk($sformatf("row%0d faultCause", i), r_cause, tbl[i].cause);
      chk($sformatf("row%0d latency", i), r_lat, tbl[i].lat);
      chk($sformatf("row%0d busReq cycles", i), r_busy, tbl[i].busy);
      chk($sformatf("row%0d stall cycles", i), r_stl, tbl[i].stl);
      chk($sformatf("row%0d bus stable", i), r_stable, 1);
      @(negedge clk);
      #1;
      chk($sformatf("row%0d done pulse width", i), {done, fault}, 0);
    end

    // Stray ack while idle must not complete anything or touch loadData.
    @(negedge clk);
    bif.busAck = 1'b1; bif.busRdata = 32'h11111111;
    @(negedge clk);
    bif.busAck = 1'b0;
    #1;
    chk("idle ack done", {done, stall, bif.busReq}, 0);
    @(negedge clk);
    #1;
    chk("idle ack loadData", loadData, 32'h0000007F);

    // Async reset in the middle of an outstanding LW.
    @(negedge clk);
    memRead = 1'b1; funct3 = 3'b010; address = 32'h00001010;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre-reset busReq", bif.busReq, 1);
    rst_n = 1'b0;
    #1;
    chk("reset busReq", bif.busReq, 0);
    chk("reset stall", stall, 0);
    chk("reset done", done, 0);
    memRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post-reset idle", {stall, done, bif.busReq}, 0);
    run_access('{1, 0, 3'b010, 32'h00001014, 32'h0, 1, 32'hCAFEF00D, 32'hCAFEF00D,
                 32'h00001014, 4'b1111, 32'h0, 0, 0, 2'b00, 3, 1, 2},
               r_addr, r_wd, r_be, r_we, r_flt, r_cause, r_lat, r_busy, r_stl, r_stable, r_ok);
    chk("post-reset LW completed", r_ok, 1);
    chk("post-reset LW loadData", loadData, 32'hCAFEF00D);
    chk("post-reset LW busAddr", r_addr, 32'h00001014);
    chk("post-reset LW latency", r_lat, 3);
    chk("post-reset LW fault", {r_flt, r_cause}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
